// File: rtl/control_unit.sv
// rtl/control_unit.sv - FETCH/DECODE/EXEC sequencer driving A/B/OUT load strobes
module control_unit #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        instr,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        imm_data,
    output logic              src_sel,
    output logic              alu_op,
    output logic              ld_a,
    output logic              ld_b,
    output logic              ld_out,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t            state;
    logic [7:0]        ir;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] jump_target;

    assign opcode      = ir[7:4];
    assign jump_target = ADDR_W'(ir[3:0]);
    assign imm_data    = {4'b0000, ir[3:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            pc     <= '0;
            ir     <= 8'h00;
            halted <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= instr;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    pc    <= pc + ADDR_W'(1);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    case (opcode)
                        OP_JMP: pc <= jump_target;
                        OP_JZ:  if (alu_zero) pc <= jump_target;
                        OP_HLT: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Strobes are masked by reset so a reset landing in EXEC never loads a register.
    always_comb begin
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_out  = 1'b0;
        src_sel = 1'b0;
        alu_op  = 1'b0;
        if (state == S_EXEC && !reset) begin
            case (opcode)
                OP_LDA: ld_a = 1'b1;
                OP_LDB: ld_b = 1'b1;
                OP_ADD: begin
                    ld_a    = 1'b1;
                    src_sel = 1'b1;
                end
                OP_SUB: begin
                    ld_a    = 1'b1;
                    src_sel = 1'b1;
                    alu_op  = 1'b1;
                end
                OP_OUT: begin
                    ld_out  = 1'b1;
                    src_sel = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instr;
    logic       alu_zero;
    logic [3:0] pc;
    logic [7:0] imm_data;
    logic       src_sel, alu_op, ld_a, ld_b, ld_out, halted;

    logic [7:0] rom [16];
    int n_cmp = 0;
    int n_err = 0;

    control_unit #(.ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero),
        .pc(pc), .imm_data(imm_data), .src_sel(src_sel), .alu_op(alu_op),
        .ld_a(ld_a), .ld_b(ld_b), .ld_out(ld_out), .halted(halted)
    );

    always #5 clk = ~clk;
    assign instr = rom[pc];

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    // Leaves the bench in cycle 0 (FETCH of pc=0), just after the releasing edge.
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
        reset = 1'b0;
        alu_zero = 1'($urandom);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({ld_a, ld_b, ld_out} !== 3'b000) begin
                n_err++; $display("FAIL reset_strobes cyc%0d: got %b want 000", c, {ld_a, ld_b, ld_out});
            end
            @(posedge clk);
        end
        #1 reset = 1'b0;
        clear_rom();
        rom[0] = 8'h11;
        @(negedge clk);
        n_cmp++;
        if (pc !== 4'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", pc); end
        n_cmp++;
        if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++;
        if (imm_data !== 8'h00) begin n_err++; $display("FAIL reset_ir: got %h want 00", imm_data); end
        // Starting in FETCH means the LDA at pc 0 strobes exactly two cycles later.
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (ld_a !== 1'b1 || imm_data !== 8'h01) begin
            n_err++; $display("FAIL reset_fetch_state: ld_a=%b imm=%h want 1/01", ld_a, imm_data);
        end
    endtask

    task automatic test_program();
        clear_rom();
        rom[0] = 8'h13; rom[1] = 8'h22; rom[2] = 8'h30; rom[3] = 8'h50;
        alu_zero = 1'b0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            logic [6:0] exp;   // {ld_a, ld_b, ld_out, src_sel, alu_op, imm[1:0]}
            if (c != 0) @(posedge clk);
            @(negedge clk);
            case (c)
                2:       exp = 7'b1_0_0_0_0_11;
                5:       exp = 7'b0_1_0_0_0_10;
                8:       exp = 7'b1_0_0_1_0_00;
                11:      exp = 7'b0_0_1_1_0_00;
                default: exp = {5'b0, imm_data[1:0]};
            endcase
            n_cmp++;
            if ({ld_a, ld_b, ld_out, src_sel, alu_op, imm_data[1:0]} !== exp) begin
                n_err++;
                $display("FAIL program cyc%0d: got %b want %b", c,
                         {ld_a, ld_b, ld_out, src_sel, alu_op, imm_data[1:0]}, exp);
            end
        end
    endtask

    task automatic test_sub();
        clear_rom();
        rom[0] = 8'h49;
        do_reset();
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_cmp++;
        if ({ld_a, src_sel, alu_op, imm_data} !== {3'b111, 8'h09}) begin
            n_err++; $display("FAIL sub: got %b/%h want 111/09", {ld_a, src_sel, alu_op}, imm_data);
        end
    endtask

    task automatic test_jmp();
        logic [3:0] exp_pc [4] = '{4'd0, 4'd1, 4'd5, 4'd6};
        clear_rom();
        rom[0] = 8'h65; rom[5] = 8'h17;
        do_reset();
        // pc observed in FETCH, DECODE+1 (after increment), FETCH of target, after its increment
        @(negedge clk);
        n_cmp++; if (pc !== exp_pc[0]) begin n_err++; $display("FAIL jmp_pc0: got %0d want %0d", pc, exp_pc[0]); end
        @(negedge clk); @(negedge clk);
        n_cmp++; if (pc !== exp_pc[1]) begin n_err++; $display("FAIL jmp_pc1: got %0d want %0d", pc, exp_pc[1]); end
        @(negedge clk);
        n_cmp++; if (pc !== exp_pc[2]) begin n_err++; $display("FAIL jmp_pc2: got %0d want %0d", pc, exp_pc[2]); end
        @(negedge clk); @(negedge clk);
        n_cmp++; if (pc !== exp_pc[3]) begin n_err++; $display("FAIL jmp_pc3: got %0d want %0d", pc, exp_pc[3]); end
        n_cmp++;
        if (ld_a !== 1'b1 || imm_data !== 8'h07 || src_sel !== 1'b0) begin
            n_err++; $display("FAIL jmp_lda: ld_a=%b imm=%h src=%b want 1/07/0", ld_a, imm_data, src_sel);
        end
    endtask

    task automatic test_jz();
        for (int z = 1; z >= 0; z--) begin
            logic [3:0] want;
            want = (z == 1) ? 4'd10 : 4'd1;
            clear_rom();
            rom[0] = 8'h7A;
            alu_zero = 1'(z);
            do_reset();
            repeat (4) @(negedge clk);
            n_cmp++;
            if (pc !== want) begin n_err++; $display("FAIL jz_z%0d: got pc %0d want %0d", z, pc, want); end
            n_cmp++;
            if ({ld_a, ld_b, ld_out} !== 3'b000) begin
                n_err++; $display("FAIL jz_strobes_z%0d: got %b want 000", z, {ld_a, ld_b, ld_out});
            end
        end
        alu_zero = 1'b0;
    endtask

    task automatic test_wrap_halt();
        clear_rom();
        rom[0] = 8'h6F; rom[15] = 8'h00;
        do_reset();
        repeat (4) @(negedge clk);
        n_cmp++; if (pc !== 4'd15) begin n_err++; $display("FAIL wrap_at15: got %0d want 15", pc); end
        repeat (2) @(negedge clk);
        n_cmp++; if (pc !== 4'd0) begin n_err++; $display("FAIL wrap_to0: got %0d want 0", pc); end

        clear_rom();
        rom[0] = 8'hF0;
        do_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_early: got %b want 0", halted); end
        for (int i = 0; i < 16; i++) rom[i] = 8'h13;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({halted, pc, ld_a, ld_b, ld_out, imm_data} !== {1'b1, 4'd1, 3'b000, 8'h00}) begin
                n_err++;
                $display("FAIL halt_hold cyc%0d: halted=%b pc=%0d strobes=%b imm=%h want 1/1/000/00",
                         c, halted, pc, {ld_a, ld_b, ld_out}, imm_data);
            end
        end
    endtask

    task automatic test_reset_in_exec();
        clear_rom();
        rom[0] = 8'h13;
        do_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (ld_a !== 1'b0) begin n_err++; $display("FAIL rst_exec_lda: got %b want 0", ld_a); end
        @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++; if (pc !== 4'd0) begin n_err++; $display("FAIL rst_exec_pc: got %0d want 0", pc); end
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_cmp++;
        if (ld_a !== 1'b1 || imm_data !== 8'h03) begin
            n_err++; $display("FAIL rst_exec_refetch: ld_a=%b imm=%h want 1/03", ld_a, imm_data);
        end

        rom[0] = 8'hF0;
        do_reset();
        repeat (5) @(negedge clk);
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL rst_halt_pre: got %b want 1", halted); end
        rom[0] = 8'h22;
        do_reset();
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halt_clear: got %b want 0", halted); end
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_cmp++;
        if (ld_b !== 1'b1 || imm_data !== 8'h02) begin
            n_err++; $display("FAIL rst_halt_resume: ld_b=%b imm=%h want 1/02", ld_b, imm_data);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (32'(ld_a) + 32'(ld_b) + 32'(ld_out)) > 1) begin
            n_cmp++;
            n_err++;
            $display("FAIL strobe_exclusive: got %b want at most one", {ld_a, ld_b, ld_out});
        end
    end

    initial begin
        reset = 1'b1;
        alu_zero = 1'b0;
        clear_rom();
        test_reset();
        test_program();
        test_sub();
        test_jmp();
        test_jz();
        test_wrap_halt();
        test_reset_in_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
